// File: rtl/quant_pkg.sv
// Shared constants for the quantizer: default JPEG q tables, reciprocal helper, FSM states.
package quant_pkg;

    typedef logic [0:0] state_t;
    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Standard JPEG luminance quantization table, row-major.
    localparam logic [7:0] LUMA_Q [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    // Standard JPEG chrominance quantization table, row-major.
    localparam logic [7:0] CHROMA_Q [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    // floor(2^w / q); q = 0 maps to 0 so the datapath outputs 0.
    function automatic logic [31:0] recip(input logic [7:0] q, input int unsigned w);
        logic [32:0] num;
        if (q == 8'd0) begin
            return '0;
        end
        num = 33'd1 << w;
        return 32'(num / {25'd0, q});
    endfunction

endpackage

// File: rtl/quant_table_ram.sv
// Reciprocal storage: NUM_TABLES x 64 entries, one write port, one registered read port.
module quant_table_ram #(
    parameter int unsigned RECIP_WIDTH = 16,
    parameter int unsigned NUM_TABLES  = 2,
    parameter int unsigned SEL_WIDTH   = 1
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic                   wr_bcast,
    input  logic [SEL_WIDTH-1:0]   wr_sel,
    input  logic [5:0]             wr_addr,
    input  logic [RECIP_WIDTH-1:0] wr_data,
    input  logic [RECIP_WIDTH-1:0] wr_data_alt,
    input  logic                   rd_en,
    input  logic [SEL_WIDTH-1:0]   rd_sel,
    input  logic [5:0]             rd_addr,
    output logic [RECIP_WIDTH-1:0] rd_data
);

    logic [RECIP_WIDTH-1:0] mem [NUM_TABLES*64];

    // Read samples the pre-write contents; broadcast writes table 0 with wr_data, others alt.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[{rd_sel, rd_addr}];
        end
        if (wr_en) begin
            if (wr_bcast) begin
                for (int t = 0; t < int'(NUM_TABLES); t++) begin
                    mem[{SEL_WIDTH'(t), wr_addr}] <= (t == 0) ? wr_data : wr_data_alt;
                end
            end else begin
                mem[{wr_sel, wr_addr}] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/quant_engine.sv
// JPEG quantizer: table lookup, multiply by reciprocal, round and saturate; 3-stage pipeline.
module quant_engine
    import quant_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH   = DATA_WIDTH,
    parameter int unsigned RECIP_WIDTH = 16,
    parameter int unsigned NUM_TABLES  = 2,
    parameter bit          ROUND       = 1'b1,
    localparam int unsigned SEL_WIDTH  = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [5:0]             in_addr,
    input  logic [SEL_WIDTH-1:0]   in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [5:0]             out_addr,
    output logic                   out_sat,
    input  logic                   tbl_wr_en,
    input  logic [SEL_WIDTH-1:0]   tbl_wr_sel,
    input  logic [5:0]             tbl_wr_addr,
    input  logic [RECIP_WIDTH-1:0] tbl_wr_data,
    output logic                   init_busy
);

    localparam int unsigned PW = DATA_WIDTH + RECIP_WIDTH + 1;
    localparam logic [PW-1:0] HALF    = ROUND ? (PW'(1) << (RECIP_WIDTH - 1)) : PW'(0);
    localparam logic [PW-1:0] POS_LIM = (PW'(1) << (OUT_WIDTH - 1)) - PW'(1);
    localparam logic [PW-1:0] NEG_MAG = PW'(1) << (OUT_WIDTH - 1);

    state_t state;
    logic [5:0] init_cnt;
    logic run, stall;

    assign run       = (state == ST_RUN);
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = run & ~stall;
    assign init_busy = ~run;

    // INIT walks the 64 entries once, then hands the table over to the external port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 6'd1;
            if (init_cnt == 6'd63) begin
                state <= ST_RUN;
            end
        end
    end

    logic                   ram_wr_en, ram_bcast;
    logic [SEL_WIDTH-1:0]   ram_wr_sel;
    logic [5:0]             ram_wr_addr;
    logic [RECIP_WIDTH-1:0] ram_wr_data, ram_wr_alt, s1_recip;

    // Write-port mux: defaults broadcast to all tables during INIT, external port in RUN.
    always_comb begin
        ram_wr_en   = tbl_wr_en;
        ram_bcast   = 1'b0;
        ram_wr_sel  = tbl_wr_sel;
        ram_wr_addr = tbl_wr_addr;
        ram_wr_data = tbl_wr_data;
        ram_wr_alt  = '0;
        if (!run) begin
            ram_wr_en   = 1'b1;
            ram_bcast   = 1'b1;
            ram_wr_sel  = '0;
            ram_wr_addr = init_cnt;
            ram_wr_data = RECIP_WIDTH'(recip(LUMA_Q[init_cnt], RECIP_WIDTH));
            ram_wr_alt  = RECIP_WIDTH'(recip(CHROMA_Q[init_cnt], RECIP_WIDTH));
        end
    end

    // Read enable follows the pipeline so the looked-up value holds across a stall.
    quant_table_ram #(
        .RECIP_WIDTH (RECIP_WIDTH),
        .NUM_TABLES  (NUM_TABLES),
        .SEL_WIDTH   (SEL_WIDTH)
    ) u_ram (
        .clk         (clk),
        .wr_en       (ram_wr_en),
        .wr_bcast    (ram_bcast),
        .wr_sel      (ram_wr_sel),
        .wr_addr     (ram_wr_addr),
        .wr_data     (ram_wr_data),
        .wr_data_alt (ram_wr_alt),
        .rd_en       (~stall),
        .rd_sel      (in_sel),
        .rd_addr     (in_addr),
        .rd_data     (s1_recip)
    );

    logic                  s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [5:0]            s1_addr, s2_addr;
    logic [PW-1:0]         s2_prod;
    logic signed [PW-1:0]  prod_c;

    // Signed coefficient times zero-extended reciprocal.
    assign prod_c = $signed({{(RECIP_WIDTH + 1){s1_data[DATA_WIDTH-1]}}, s1_data})
                  * $signed({{(DATA_WIDTH + 1){1'b0}}, s1_recip});

    logic                 p_neg, sat_c;
    logic [PW-1:0]        p_abs, p_mag;
    logic [OUT_WIDTH-1:0] q_c;

    // Round on magnitude (symmetric about zero), then clip to the output range.
    always_comb begin
        p_neg = s2_prod[PW-1];
        p_abs = p_neg ? (~s2_prod + PW'(1)) : s2_prod;
        p_mag = (p_abs + HALF) >> RECIP_WIDTH;
        sat_c = 1'b0;
        q_c   = p_neg ? OUT_WIDTH'(~p_mag + PW'(1)) : OUT_WIDTH'(p_mag);
        if (!p_neg && (p_mag > POS_LIM)) begin
            sat_c = 1'b1;
            q_c   = OUT_WIDTH'(POS_LIM);
        end else if (p_neg && (p_mag > NEG_MAG)) begin
            sat_c = 1'b1;
            q_c   = OUT_WIDTH'(NEG_MAG);
        end
    end

    // Pipeline registers; every stage freezes together on a downstream stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid & in_ready;
            s1_data   <= in_data;
            s1_addr   <= in_addr;
            s2_valid  <= s1_valid;
            s2_prod   <= prod_c;
            s2_addr   <= s1_addr;
            out_valid <= s2_valid;
            out_data  <= q_c;
            out_addr  <= s2_addr;
            out_sat   <= s2_valid & sat_c;
        end
    end

endmodule

// File: tb/tb_quant_engine.sv
// Bench for quant_engine: a rounding 10-bit instance and a truncating 8-bit instance share stimulus.
module tb_quant_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, tbl_wr_en;
    logic [9:0]  in_data;
    logic [5:0]  in_addr, tbl_wr_addr;
    logic [0:0]  in_sel, tbl_wr_sel;
    logic [15:0] tbl_wr_data;

    logic       a_in_ready, a_out_valid, a_out_sat, a_init_busy;
    logic [9:0] a_out_data;
    logic [5:0] a_out_addr;
    logic       b_in_ready, b_out_valid, b_out_sat, b_init_busy;
    logic [7:0] b_out_data;
    logic [5:0] b_out_addr;

    quant_engine #(.DATA_WIDTH(10), .OUT_WIDTH(10), .RECIP_WIDTH(16), .NUM_TABLES(2), .ROUND(1'b1))
    u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_sel(in_sel), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_addr(a_out_addr), .out_sat(a_out_sat),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data), .init_busy(a_init_busy)
    );

    quant_engine #(.DATA_WIDTH(10), .OUT_WIDTH(8), .RECIP_WIDTH(16), .NUM_TABLES(2), .ROUND(1'b0))
    u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_sel(in_sel), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_addr(b_out_addr), .out_sat(b_out_sat),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data), .init_busy(b_init_busy)
    );

    int tests = 0;
    int fails = 0;
    int tbl [2][64];

    int luma_q [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
    int chroma_q [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

    typedef struct {
        int addr;
        int da;
        bit sa;
        int db;
        bit sb;
    } exp_t;

    // Reference quantizer: scaled product, rounding on magnitude, then clip.
    function automatic int quant(input int d, input int r, input bit rnd, input int ow,
                                 output bit sat);
        longint p, a, m, v, hi, lo;
        p = longint'(d) * longint'(r);
        a = (p < 0) ? -p : p;
        m = rnd ? (a + 32768) / 65536 : a / 65536;
        v = (p < 0) ? -m : m;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        sat = 1'b0;
        if (v > hi) begin
            v = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            v = lo;
            sat = 1'b1;
        end
        return int'(v);
    endfunction

    task automatic model_defaults();
        for (int k = 0; k < 64; k++) begin
            tbl[0][k] = 65536 / luma_q[k];
            tbl[1][k] = 65536 / chroma_q[k];
        end
    endtask

    task automatic write_tbl(input int sel, input int addr, input int val);
        @(negedge clk);
        tbl_wr_en   = 1'b1;
        tbl_wr_sel  = 1'(sel);
        tbl_wr_addr = 6'(addr);
        tbl_wr_data = 16'(val);
        @(negedge clk);
        tbl_wr_en = 1'b0;
        tbl[sel][addr] = val;
    endtask

    // Drives one coefficient (optionally with a same-cycle table 0 write) and waits for its result.
    task automatic send_one(input int sel, input int addr, input int data, input bit wr,
                            input int waddr, input int wval,
                            output int ga, output bit sa, output int gb, output bit sb,
                            output int lat);
        int n;
        @(negedge clk);
        in_valid    = 1'b1;
        in_sel      = 1'(sel);
        in_addr     = 6'(addr);
        in_data     = 10'(data);
        out_ready   = 1'b1;
        tbl_wr_en   = wr;
        tbl_wr_sel  = 1'b0;
        tbl_wr_addr = 6'(waddr);
        tbl_wr_data = 16'(wval);
        #1;
        n = 0;
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        tbl_wr_en = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        ga = $signed(a_out_data);
        sa = a_out_sat;
        gb = $signed(b_out_data);
        sb = b_out_sat;
    endtask

    task automatic test_reset();
        int edges;
        bit busy63;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (a_out_valid !== 1'b0 || a_out_data !== 10'd0 || a_out_addr !== 6'd0 ||
            a_out_sat !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_a: valid=%b data=%0d addr=%0d sat=%b, need all 0",
                     a_out_valid, a_out_data, a_out_addr, a_out_sat);
        end
        tests++;
        if (a_in_ready !== 1'b0 || a_init_busy !== 1'b1 || b_in_ready !== 1'b0 ||
            b_init_busy !== 1'b1 || b_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: in_ready=%b/%b init_busy=%b/%b, need 0/0 1/1",
                     a_in_ready, b_in_ready, a_init_busy, b_init_busy);
        end
        rst = 1'b0;
        edges = 0;
        busy63 = 1'b0;
        #1;
        while (!a_in_ready && edges < 200) begin
            @(negedge clk);
            edges++;
            #1;
            if (edges == 63) busy63 = a_init_busy && !a_in_ready;
        end
        tests++;
        if (edges != 64 || a_init_busy !== 1'b0 || b_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL init_done: ready after %0d edges busy=%b, need 64 edges busy=0",
                     edges, a_init_busy);
        end
        tests++;
        if (!busy63) begin
            fails++;
            $display("FAIL init_busy63: busy=0 one cycle before ready, need busy=1");
        end
        tests++;
        if (u_a.u_ram.mem[0] !== 16'd4096 || u_a.u_ram.mem[64] !== 16'd3855) begin
            fails++;
            $display("FAIL default_readback: t0[0]=%0d t1[0]=%0d, need 4096 3855",
                     u_a.u_ram.mem[0], u_a.u_ram.mem[64]);
        end
        model_defaults();
    endtask

    task automatic test_rounding();
        int sel_v [4] = '{0, 0, 0, 1};
        int dat_v [4] = '{160, 100, -24, 170};
        int ea_v  [4] = '{10, 6, -2, 10};
        int eb_v  [4] = '{10, 6, -1, 9};
        int ga, gb, lat;
        bit sa, sb;
        for (int i = 0; i < 4; i++) begin
            send_one(sel_v[i], 0, dat_v[i], 1'b0, 0, 0, ga, sa, gb, sb, lat);
            tests++;
            if (ga != ea_v[i] || gb != eb_v[i] || sa || sb) begin
                fails++;
                $display("FAIL round_%0d: in=%0d got round=%0d trunc=%0d sat=%b%b, need %0d %0d 00",
                         i, dat_v[i], ga, gb, sa, sb, ea_v[i], eb_v[i]);
            end
            if (i == 0) begin
                tests++;
                if (lat != 3) begin
                    fails++;
                    $display("FAIL latency: got %0d cycles, need 3", lat);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int ga, gb, lat;
        bit sa, sb;
        write_tbl(0, 5, 65535);
        send_one(0, 5, 511, 1'b0, 0, 0, ga, sa, gb, sb, lat);
        tests++;
        if (gb != 127 || sb !== 1'b1 || ga != 511 || sa !== 1'b0) begin
            fails++;
            $display("FAIL sat_pos: got w8=%0d/%b w10=%0d/%b, need 127/1 511/0", gb, sb, ga, sa);
        end
        send_one(0, 5, -512, 1'b0, 0, 0, ga, sa, gb, sb, lat);
        tests++;
        if (gb != -128 || sb !== 1'b1 || ga != -512 || sa !== 1'b0) begin
            fails++;
            $display("FAIL sat_neg: got w8=%0d/%b w10=%0d/%b, need -128/1 -512/0", gb, sb, ga, sa);
        end
    endtask

    task automatic test_rbw();
        int ga, gb, lat;
        bit sa, sb;
        send_one(0, 0, 160, 1'b1, 0, 8192, ga, sa, gb, sb, lat);
        tbl[0][0] = 8192;
        tests++;
        if (ga != 10 || gb != 10) begin
            fails++;
            $display("FAIL rbw_old: got %0d/%0d, need 10/10", ga, gb);
        end
        send_one(0, 0, 160, 1'b0, 0, 0, ga, sa, gb, sb, lat);
        tests++;
        if (ga != 20 || gb != 20) begin
            fails++;
            $display("FAIL rbw_new: got %0d/%0d, need 20/20", ga, gb);
        end
    endtask

    task automatic test_backpressure();
        exp_t q [$];
        exp_t e;
        int sent, recv, cyc, d, r;
        bit prev_stall, s_sa, s_sb;
        logic [9:0] s_da;
        logic [7:0] s_db;
        logic [5:0] s_addr;
        sent = 0;
        recv = 0;
        cyc = 0;
        prev_stall = 1'b0;
        s_da = '0;
        s_db = '0;
        s_addr = '0;
        s_sa = 1'b0;
        s_sb = 1'b0;
        while ((sent < 64 || recv < 64) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                tests++;
                if (a_out_valid !== 1'b1 || a_out_data !== s_da || a_out_addr !== s_addr ||
                    a_out_sat !== s_sa || b_out_data !== s_db || b_out_sat !== s_sb) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b addr=%0d a=%0d b=%0d, need v=1 %0d %0d %0d",
                             a_out_valid, a_out_addr, a_out_data, b_out_data, s_addr, s_da, s_db);
                end
            end
            in_valid    = (sent < 64) && ($urandom_range(3) != 0);
            in_sel      = 1'($urandom_range(1));
            in_addr     = 6'(sent);
            in_data     = 10'($urandom_range(1023));
            out_ready   = 1'($urandom_range(1));
            tbl_wr_en   = ($urandom_range(7) == 0);
            tbl_wr_sel  = 1'($urandom_range(1));
            tbl_wr_addr = 6'($urandom_range(63));
            tbl_wr_data = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom_range(65535));
            #1;
            if (in_valid && a_in_ready) begin
                d = $signed(in_data);
                r = tbl[in_sel][in_addr];
                e.addr = sent;
                e.da = quant(d, r, 1'b1, 10, e.sa);
                e.db = quant(d, r, 1'b0, 8, e.sb);
                q.push_back(e);
                sent++;
            end
            if (tbl_wr_en) tbl[tbl_wr_sel][tbl_wr_addr] = tbl_wr_data;
            if (a_out_valid && out_ready) begin
                tests++;
                recv++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: unexpected output addr=%0d", a_out_addr);
                end else begin
                    e = q.pop_front();
                    if (int'(a_out_addr) != e.addr || int'(b_out_addr) != e.addr ||
                        int'($signed(a_out_data)) != e.da || a_out_sat != e.sa ||
                        int'($signed(b_out_data)) != e.db || b_out_sat != e.sb) begin
                        fails++;
                        $display("FAIL bp_out: got addr=%0d a=%0d/%b b=%0d/%b, need addr=%0d a=%0d/%b b=%0d/%b",
                                 a_out_addr, $signed(a_out_data), a_out_sat, $signed(b_out_data),
                                 b_out_sat, e.addr, e.da, e.sa, e.db, e.sb);
                    end
                end
            end
            prev_stall = a_out_valid && !out_ready;
            s_da = a_out_data;
            s_db = b_out_data;
            s_addr = a_out_addr;
            s_sa = a_out_sat;
            s_sb = b_out_sat;
        end
        tests++;
        if (sent != 64 || recv != 64 || q.size() != 0) begin
            fails++;
            $display("FAIL bp_count: sent=%0d recv=%0d pending=%0d, need 64 64 0",
                     sent, recv, q.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        tbl_wr_en = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        int n, ga, gb, lat;
        bit sa, sb, seen_valid;
        write_tbl(0, 0, 8192);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_addr = 6'(i);
            in_data = 10'(100 + i);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_init_busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: out_valid=%b/%b busy=%b, need 0/0 1",
                     a_out_valid, b_out_valid, a_init_busy);
        end
        rst = 1'b0;
        n = 0;
        seen_valid = 1'b0;
        #1;
        while (!a_in_ready && n < 200) begin
            tbl_wr_en   = (n < 60);
            tbl_wr_sel  = 1'b0;
            tbl_wr_addr = 6'd0;
            tbl_wr_data = 16'd1;
            @(negedge clk);
            n++;
            #1;
            if (a_out_valid || b_out_valid) seen_valid = 1'b1;
        end
        tbl_wr_en = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (seen_valid || n != 64) begin
            fails++;
            $display("FAIL rst_reinit: stale_valid=%b ready after %0d edges, need 0 64",
                     seen_valid, n);
        end
        model_defaults();
        send_one(0, 0, 160, 1'b0, 0, 0, ga, sa, gb, sb, lat);
        tests++;
        if (ga != 10 || gb != 10) begin
            fails++;
            $display("FAIL rst_revert: got %0d/%0d, need 10/10", ga, gb);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_addr = '0;
        in_sel = '0;
        out_ready = 1'b1;
        tbl_wr_en = 1'b0;
        tbl_wr_sel = '0;
        tbl_wr_addr = '0;
        tbl_wr_data = '0;
        test_reset();
        test_rounding();
        test_saturate();
        test_rbw();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quant_engine.md
# quant_engine

Pipelined, parametrised JPEG quantizer that sits between the 2-D DCT output and the zig-zag/entropy stage. It multiplies each signed DCT coefficient by a per-position reciprocal taken from one of several runtime-writable tables, then rounds and saturates the result. Flow control is a valid/ready handshake on both sides. After reset, the tables are filled automatically with the standard luma/chroma defaults.

## Interface
- `DATA_WIDTH`, 10: signed coefficient input width.
- `OUT_WIDTH`, `DATA_WIDTH`: signed quantized output width.
- `RECIP_WIDTH`, 16: unsigned reciprocal width; the reciprocal scale is 2^`RECIP_WIDTH`.
- `NUM_TABLES`, 2: number of selectable tables. Table 0 is luma; tables 1..`NUM_TABLES`-1 are chroma.
- `ROUND`, 1: 1 = round half away from zero; 0 = truncate toward zero.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input coefficient is valid.
- `in_ready` out 1: block accepts the input coefficient.
- `in_data` in `DATA_WIDTH`: signed coefficient.
- `in_addr` in 6: coefficient position 0..63 (row-major).
- `in_sel` in $clog2(`NUM_TABLES`): table select for this coefficient.
- `out_valid` out 1: output is valid.
- `out_ready` in 1: downstream accepts the output.
- `out_data` out `OUT_WIDTH`: quantized coefficient.
- `out_addr` out 6: `in_addr` carried through the pipeline.
- `out_sat` out 1: this output was clipped by saturation.
- `tbl_wr_en` in 1: table write strobe.
- `tbl_wr_sel` in $clog2(`NUM_TABLES`): table to write.
- `tbl_wr_addr` in 6: table entry to write.
- `tbl_wr_data` in `RECIP_WIDTH`: reciprocal value to write.
- `init_busy` out 1: default table load is in progress.

## Operation
- FSM states are INIT and RUN.
- `rst` forces INIT and clears the address counter.
- INIT writes entry k of every table on cycle k, for k = 0..63.
  - Value written is floor(2^`RECIP_WIDTH`/q), where q comes from the package default luma or chroma table.
  - After k = 63 the FSM moves to RUN.
- In INIT, `init_busy`=1 and `in_ready`=0. External `tbl_wr_en` is ignored.
- In RUN, `tbl_wr_en` writes one entry per cycle.
  - If a write and a lookup hit the same entry in the same cycle, the lookup returns the old value (read-before-write).
- Arithmetic:
  - p = `in_data` (signed) × reciprocal (zero-extended unsigned), computed at width `DATA_WIDTH`+`RECIP_WIDTH`+1.
  - With `ROUND`=1, the result is sign(p)·floor((|p| + 2^(`RECIP_WIDTH`-1)) / 2^`RECIP_WIDTH`).
  - With `ROUND`=0, the result is sign(p)·floor(|p| / 2^`RECIP_WIDTH`).
- Saturation: the result is clipped to [-2^(`OUT_WIDTH`-1), 2^(`OUT_WIDTH`-1)-1]. `out_sat`=1 exactly when clipping occurred.
- A reciprocal of 0 yields `out_data`=0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `out_sat`=0, `in_ready`=0, `init_busy`=1. All pipeline valid bits are cleared.
- The first cycle with `in_ready`=1 is cycle 65 after `rst` deasserts.
- Pipeline stages:
  - S1: registered table read.
  - S2: registered product.
  - S3: registered round and saturate.
- Latency is 3 accepted cycles from the input handshake to `out_valid`. Throughput is 1 coefficient per cycle.
- The stall is global: `stall` = `out_valid` & !`out_ready`. All stages hold while stalled.
- `in_ready` = RUN & !`stall`. A transfer occurs when valid & ready.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Bubbles (`in_valid`=0) propagate as invalid stages; there is no compaction.
- Table writes are not blocked by `stall`.
- `rst` in RUN drops in-flight data, clears the pipeline, and reloads the defaults over any runtime-written values.

## Structure
- Package `quant_pkg` holds:
  - default luma and chroma q arrays (64 × 8-bit);
  - function `recip(q, w)` = floor(2^w/q);
  - FSM state typedef.
- Sub-module `quant_table_ram` holds `NUM_TABLES`×64 × `RECIP_WIDTH` storage, one write port, and one synchronous read port with read-before-write behaviour.
- The top level contains the INIT counter/FSM, write-port muxing (INIT vs external), the 3-stage datapath, and stall logic.

## Test plan
- Reset release, then poll: `init_busy` falls and `in_ready` rises at cycle 65. Reading back the defaults gives table 0 entry 0 = 4096 and table 1 entry 0 = 3855.
- Table 0, addr 0, `ROUND`=1:
  - `in_data` 160 → 10.
  - 100 → 6.
  - -24 → -2.
  - With `ROUND`=0, -24 → -1.
- Table 1, addr 0: `in_data` 170 → 10 with `ROUND`=1; → 9 with `ROUND`=0.
- `OUT_WIDTH`=8: write 65535 to table 0 addr 5, then send 511 at addr 5 → `out_data`=127, `out_sat`=1. Sending -512 gives -128, `out_sat`=1.
- Backpressure: stream 64 coefficients while toggling `out_ready` randomly. All 64 outputs appear in order with correct `out_addr`, none lost or duplicated, and outputs stay stable while stalled.
- In RUN, write table 0 addr 0 = 8192 in the same cycle a lookup of addr 0 with 160 is accepted → 10. The next lookup of 160 gives 20. Asserting `rst` mid-stream gives `out_valid`=0 the next cycle and the entry reverts to 4096.
